// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH glitch-free clock dividers with double-buffered half-period divisors.
// Optional build macro CLKDIV_SYNC_EN adds the sync_in phase-alignment input.
module clk_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 16,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_data,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [DIV_W-1:0]  r_cnt     [NUM_CH];
    logic [DIV_W-1:0]  r_div_act [NUM_CH];
    logic [DIV_W-1:0]  r_div_sh  [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;

    logic [DIV_W-1:0]  w_eff_sh  [NUM_CH];
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_eff_pend;
    logic [NUM_CH-1:0] w_term;
    logic              w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // A write in the current cycle is folded into the shadow/pending view so that
    // a write landing on a boundary cycle is applied at that same boundary.
    always_comb begin
        w_wr_hit   = '0;
        w_eff_pend = '0;
        w_term     = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_eff_sh[ch]   = r_div_sh[ch];
            w_wr_hit[ch]   = div_wr && (div_ch == CH_W'(ch));
            if (w_wr_hit[ch]) begin
                w_eff_sh[ch] = div_data;
            end
            w_eff_pend[ch] = r_pend[ch] | w_wr_hit[ch];
            w_term[ch]     = (r_div_act[ch] != '0) &&
                             (r_cnt[ch] >= (r_div_act[ch] - DIV_W'(1)));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch]     <= '0;
                r_div_act[ch] <= DIV_W'(DEFAULT_DIV);
                r_div_sh[ch]  <= DIV_W'(DEFAULT_DIV);
                r_pend[ch]    <= 1'b0;
                r_clk[ch]     <= 1'b0;
                r_tick[ch]    <= 1'b0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_div_sh[ch] <= w_eff_sh[ch];
                r_tick[ch]   <= 1'b0;
                if (w_sync) begin
                    r_cnt[ch]  <= '0;
                    r_clk[ch]  <= 1'b0;
                    r_pend[ch] <= 1'b0;
                    if (w_eff_pend[ch]) begin
                        r_div_act[ch] <= w_eff_sh[ch];
                    end
                end else if (!enable) begin
                    r_pend[ch] <= w_eff_pend[ch];
                end else if (r_div_act[ch] == '0) begin
                    // Stopped channel: held low; a pending divisor restarts it from cnt=0.
                    r_cnt[ch]  <= '0;
                    r_clk[ch]  <= 1'b0;
                    r_pend[ch] <= 1'b0;
                    if (w_eff_pend[ch]) begin
                        r_div_act[ch] <= w_eff_sh[ch];
                    end
                end else if (w_term[ch]) begin
                    r_cnt[ch]  <= '0;
                    r_clk[ch]  <= ~r_clk[ch];
                    r_tick[ch] <= 1'b1;
                    r_pend[ch] <= 1'b0;
                    if (w_eff_pend[ch]) begin
                        r_div_act[ch] <= w_eff_sh[ch];
                    end
                end else begin
                    r_cnt[ch]  <= r_cnt[ch] + DIV_W'(1);
                    r_pend[ch] <= w_eff_pend[ch];
                end
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: 4-channel DUT plus a 3-channel DUT for out-of-range writes.
// Define CLKDIV_SYNC_EN to also exercise sync_in.
module tb_clk_divider_multi;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic        div_wr;
    logic        div_wr3;
    logic [1:0]  div_ch;
    logic [15:0] div_data;
`ifdef CLKDIV_SYNC_EN
    logic        sync_in;
`endif
    logic [3:0]  clk_o;
    logic [3:0]  tick_o;
    logic [2:0]  clk3_o;
    logic [2:0]  tick3_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clk_divider_multi #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(16)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_data (div_data),
`ifdef CLKDIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk_o),
        .tick     (tick_o)
    );

    clk_divider_multi #(.NUM_CH(3), .DIV_W(16), .DEFAULT_DIV(16)) dut3 (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .div_wr   (div_wr3),
        .div_ch   (div_ch),
        .div_data (div_data),
`ifdef CLKDIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk3_o),
        .tick     (tick3_o)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Each step lands on the falling edge after the next rising edge.
    task automatic adv(input int n);
        repeat (n) @(negedge clk_in);
        cyc += n;
    endtask

    task automatic go(input int t);
        adv(t - cyc);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] d);
        div_wr   = 1'b1;
        div_ch   = ch;
        div_data = d;
        adv(1);
        div_wr   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        div_wr   = 1'b0;
        div_wr3  = 1'b0;
        div_ch   = '0;
        div_data = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in  = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        cyc   = 0;

        // Reset state and default divisor 16
        check("rst_clk", clk_o, 4'b0000);
        check("rst_tick", tick_o, 4'b0000);
        go(14);
        div_wr3 = 1'b1; div_ch = 2'd3; div_data = 16'd1;
        adv(1);
        div_wr3 = 1'b0; div_ch = 2'd0;
        check("def_c15_clk", clk_o, 4'b0000);
        check("def_c15_tick", tick_o, 4'b0000);
        check("oor_c15_clk", clk3_o, 3'b000);
        go(16);
        check("def_c16_clk", clk_o, 4'b1111);
        check("def_c16_tick", tick_o, 4'b1111);
        check("oor_c16_tick", tick3_o, 3'b111);
        go(17);
        check("def_c17_tick", tick_o, 4'b0000);
        check("oor_c17_tick", tick3_o, 3'b000);
        check("oor_c17_clk", clk3_o, 3'b111);
        go(31);
        check("def_c31_clk", clk_o, 4'b1111);
        go(32);
        check("def_c32_clk", clk_o, 4'b0000);
        check("def_c32_tick", tick_o, 4'b1111);
        check("oor_c32_clk", clk3_o, 3'b000);

        // ch1 div=3 written at cnt=5
        go(37);
        wr(2'd1, 16'd3);
        go(48);
        check("d3_c48_clk", clk_o, 4'b1111);
        check("d3_c48_tick", tick_o, 4'b1111);
        go(50);
        check("d3_c50_tick", tick_o, 4'b0000);
        go(51);
        check("d3_c51_clk", clk_o, 4'b1101);
        check("d3_c51_tick", tick_o, 4'b0010);
        go(54);
        check("d3_c54_clk", clk_o, 4'b1111);
        go(57);
        check("d3_c57_clk", clk_o, 4'b1101);

        // ch2 stopped with div=0, then restarted with div=4
        wr(2'd2, 16'd0);
        go(64);
        check("stop_c64_clk", clk_o, 4'b0000);
        check("stop_c64_tick", tick_o, 4'b1101);
        go(66);
        check("stop_c66_clk", clk_o, 4'b0010);
        check("stop_c66_tick", tick_o, 4'b0010);
        wr(2'd2, 16'd4);
        go(70);
        check("d4_c70_clk", clk_o, 4'b0000);
        check("d4_c70_tick", tick_o, 4'b0000);
        go(71);
        check("d4_c71_clk", clk_o, 4'b0100);
        check("d4_c71_tick", tick_o, 4'b0100);
        go(75);
        check("d4_c75_clk", clk_o, 4'b0000);
        check("d4_c75_tick", tick_o, 4'b0110);

        // ch0 div=1 applied at its c80 boundary
        wr(2'd0, 16'd1);
        go(79);
        check("d1_c79_clk0", clk_o[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            adv(1);
            check("d1_clk0", clk_o[0], (i % 2 == 0) ? 1'b1 : 1'b0);
            check("d1_tick0", tick_o[0], 1'b1);
        end

        // enable low for 7 cycles with ch3 at cnt=10 (ch2 sits on a terminal cycle)
        go(90);
        check("en_c90_clk", clk_o, 4'b1111);
        check("en_c90_tick", tick_o, 4'b0011);
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            adv(1);
            check("frz_clk", clk_o, 4'b1111);
            check("frz_tick", tick_o, 4'b0000);
        end
        enable = 1'b1;
        go(98);
        check("res_c98_clk", clk_o, 4'b1010);
        check("res_c98_tick", tick_o, 4'b0101);
        go(102);
        check("res_c102_clk3", clk_o[3], 1'b1);
        check("res_c102_tick3", tick_o[3], 1'b0);
        go(103);
        check("res_c103_clk3", clk_o[3], 1'b0);
        check("res_c103_tick3", tick_o[3], 1'b1);

        // Back-to-back writes on ch3, last one on the terminal cycle
        go(116);
        wr(2'd3, 16'd7);
        wr(2'd3, 16'd5);
        wr(2'd3, 16'd2);
        check("b2b_c119_clk3", clk_o[3], 1'b1);
        check("b2b_c119_tick3", tick_o[3], 1'b1);
        go(120);
        check("b2b_c120_tick3", tick_o[3], 1'b0);
        go(121);
        check("b2b_c121_clk3", clk_o[3], 1'b0);
        check("b2b_c121_tick3", tick_o[3], 1'b1);
        go(123);
        check("b2b_c123_clk3", clk_o[3], 1'b1);

`ifdef CLKDIV_SYNC_EN
        wr(2'd0, 16'd5);
        wr(2'd1, 16'd10);
        sync_in = 1'b1;
        adv(1);
        sync_in = 1'b0;
        cyc = 0;
        check("sync_clk", clk_o, 4'b0000);
        check("sync_tick", tick_o, 4'b0000);
        go(4);
        check("sync_c4_clk0", clk_o[0], 1'b0);
        go(5);
        check("sync_c5_clk0", clk_o[0], 1'b1);
        check("sync_c5_tick0", tick_o[0], 1'b1);
        go(9);
        check("sync_c9_clk1", clk_o[1], 1'b0);
        go(10);
        check("sync_c10_clk1", clk_o[1], 1'b1);
        check("sync_c10_tick1", tick_o[1], 1'b1);
        sync_in = 1'b1;
`endif

        // Mid-count reset with a simultaneous write: reset wins, defaults return
        go(cyc + 3);
        reset    = 1'b1;
        div_wr   = 1'b1;
        div_ch   = 2'd0;
        div_data = 16'd3;
        adv(1);
        reset  = 1'b0;
        div_wr = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync_in = 1'b0;
`endif
        cyc = 0;
        check("rst2_clk", clk_o, 4'b0000);
        check("rst2_tick", tick_o, 4'b0000);
        go(15);
        check("rst2_c15_clk", clk_o, 4'b0000);
        go(16);
        check("rst2_c16_clk", clk_o, 4'b1111);
        check("rst2_c16_tick", tick_o, 4'b1111);
        go(19);
        check("rst2_c19_clk", clk_o, 4'b1111);
        check("rst2_c19_tick", tick_o, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
